ec_control_unit: RTL and testbench

Finite-state controller that sequences the 8-bit accumulator datapath (PC/IR, 32×8 RAM, A register with add/sub). It decodes the 3-bit opcode in IR, steps each instruction through fetch/decode/execute, and drives the datapath control lines. It also handles the keyboard-style Enter handshake for IN, halts on HALT, and exposes state and instruction-count debug outputs.

---
 rtl/ec_control_unit.sv | 151 +++++++++++++++
 tb/tb_ec_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ec_control_unit.sv
// ec_control_unit
// ---------------
// Sequencing FSM for the 8-bit accumulator datapath (PC/IR, 32x8 RAM,
// A register with add/sub). Each instruction walks FETCH -> DECODE ->
// execute state, and the controller drives the datapath control lines
// from the current state.
//
// Ports
//   Clock       in   system clock, all state changes on the rising edge
//   Reset       in   asynchronous active-high reset; forces START, clears count
//   IR[2:0]     in   opcode field of the instruction register
//   Aeq0        in   A == 0 flag
//   Apos        in   A > 0 flag (signed)
//   Enter       in   operator strobe (level, any hold time)
//   IRload      out  load instruction register
//   PCload      out  load program counter
//   JMPmux      out  PC source: 0 = PC+1, 1 = IR address field
//   Meminst     out  RAM address from IR address field
//   MemWr       out  RAM write enable
//   Aload       out  load A register
//   Sub         out  adder/subtractor mode (1 = subtract)
//   Asel[1:0]   out  A source: 00 add/sub, 01 Input, 10 RAM_Q
//   Halt        out  high while halted
//   State[3:0]  out  current state encoding (debug)
//   InstrCount  out  instructions decoded since reset, mod 256 (debug)

module ec_control_unit (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       IRload,
    output logic       PCload,
    output logic       JMPmux,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halt,
    output logic [3:0] State,
    output logic [7:0] InstrCount
);

    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_INREL  = 4'd3;
    localparam logic [3:0] S_LOAD   = 4'd8;
    localparam logic [3:0] S_STORE  = 4'd9;
    localparam logic [3:0] S_ADD    = 4'd10;
    localparam logic [3:0] S_SUB    = 4'd11;
    localparam logic [3:0] S_INPUT  = 4'd12;
    localparam logic [3:0] S_JZ     = 4'd13;
    localparam logic [3:0] S_JPOS   = 4'd14;
    localparam logic [3:0] S_HALT   = 4'd15;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [7:0] instr_count_reg;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg       <= S_START;
            instr_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                instr_count_reg <= instr_count_reg + 8'd1;
        end
    end

    // Execute states are laid out as 4'b1xxx with the opcode in the low
    // bits, so DECODE dispatches by simply prefixing the opcode.
    always_comb begin
        state_next = S_START;
        case (state_reg)
            S_START:  state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = {1'b1, IR};
            S_LOAD,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ,
            S_JPOS:   state_next = S_FETCH;
            S_INPUT:  state_next = Enter ? S_INREL : S_INPUT;
            // Wait for Enter release so one press loads A only once.
            S_INREL:  state_next = Enter ? S_INREL : S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_START;
        endcase
    end

    always_comb begin
        IRload  = 1'b0;
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = 2'b00;
        Halt    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            S_DECODE: Meminst = 1'b1;
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = 1'b1;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = 1'b1;
            end
            S_INPUT: begin
                Asel  = 2'b01;
                Aload = Enter;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_HALT: Halt = 1'b1;
            default: ;
        endcase
    end

    assign State      = state_reg;
    assign InstrCount = instr_count_reg;

endmodule

// File: tb/tb_ec_control_unit.sv
module tb_ec_control_unit;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic [2:0] IR = 3'b000;
    logic       Aeq0 = 1'b0;
    logic       Apos = 1'b0;
    logic       Enter = 1'b0;
    logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
    logic [1:0] Asel;
    logic [3:0] State;
    logic [7:0] InstrCount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ec_control_unit dut (
        .Clock      (clk),
        .Reset      (Reset),
        .IR         (IR),
        .Aeq0       (Aeq0),
        .Apos       (Apos),
        .Enter      (Enter),
        .IRload     (IRload),
        .PCload     (PCload),
        .JMPmux     (JMPmux),
        .Meminst    (Meminst),
        .MemWr      (MemWr),
        .Aload      (Aload),
        .Sub        (Sub),
        .Asel       (Asel),
        .Halt       (Halt),
        .State      (State),
        .InstrCount (InstrCount)
    );

    // Packed view: IRload PCload JMPmux Meminst MemWr Aload Sub Asel[1:0] Halt
    logic [9:0] ctrl;
    assign ctrl = {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Halt};

    localparam logic [9:0] C_NONE   = 10'b0000000000;
    localparam logic [9:0] C_FETCH  = 10'b1100000000;
    localparam logic [9:0] C_DECODE = 10'b0001000000;
    localparam logic [9:0] C_LOAD   = 10'b0001010100;
    localparam logic [9:0] C_STORE  = 10'b0001100000;
    localparam logic [9:0] C_ADD    = 10'b0001010000;
    localparam logic [9:0] C_SUB    = 10'b0001011000;
    localparam logic [9:0] C_IN0    = 10'b0000000010;
    localparam logic [9:0] C_IN1    = 10'b0000010010;
    localparam logic [9:0] C_JMP0   = 10'b0010000000;
    localparam logic [9:0] C_JMP1   = 10'b0110000000;
    localparam logic [9:0] C_HALT   = 10'b0000000001;

    // Advance one clock; sample point is 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Synchronised reset pulse; returns with the FSM in START.
    task automatic do_reset();
        @(posedge clk);
        #2;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Enter = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        tests++;
        if (State !== 4'd0 || ctrl !== C_NONE || InstrCount !== 8'd0) begin
            fails++;
            $display("FAIL reset_async: State=%0d ctrl=%b cnt=%0d, want 0 %b 0", State, ctrl, InstrCount, C_NONE);
        end
        IR = 3'b000;
        @(posedge clk);
        #2;
        Reset = 1'b0;
        #1;
        // State sequence after release: 0, 1, 2, then LOAD (8)
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_s;
            exp_s = (i == 3) ? 4'd8 : i[3:0];
            tests++;
            if (State !== exp_s) begin
                fails++;
                $display("FAIL reset_seq[%0d]: State=%0d want %0d", i, State, exp_s);
            end
            if (i < 3) step();
        end
        // InstrCount is nonzero now; an asynchronous reset between edges must clear it at once.
        tests++;
        if (InstrCount !== 8'd1) begin
            fails++;
            $display("FAIL reset_precount: cnt=%0d want 1", InstrCount);
        end
        Reset = 1'b1;
        #1;
        tests++;
        if (State !== 4'd0 || ctrl !== C_NONE || InstrCount !== 8'd0) begin
            fails++;
            $display("FAIL reset_midcycle: State=%0d ctrl=%b cnt=%0d, want 0 %b 0", State, ctrl, InstrCount, C_NONE);
        end
        step();
        Reset = 1'b0;
        $display("[TB] reset transaction done");
    endtask

    task automatic test_load();
        do_reset();
        IR = 3'b000;
        step();
        tests++;
        if (State !== 4'd1 || ctrl !== C_FETCH) begin
            fails++;
            $display("FAIL load_fetch: State=%0d ctrl=%b want 1 %b", State, ctrl, C_FETCH);
        end
        step();
        tests++;
        if (State !== 4'd2 || ctrl !== C_DECODE || InstrCount !== 8'd0) begin
            fails++;
            $display("FAIL load_decode: State=%0d ctrl=%b cnt=%0d want 2 %b 0", State, ctrl, InstrCount, C_DECODE);
        end
        step();
        tests++;
        if (State !== 4'd8 || ctrl !== C_LOAD || InstrCount !== 8'd1) begin
            fails++;
            $display("FAIL load_exec: State=%0d ctrl=%b cnt=%0d want 8 %b 1", State, ctrl, InstrCount, C_LOAD);
        end
        step();
        tests++;
        if (State !== 4'd1 || ctrl !== C_FETCH) begin
            fails++;
            $display("FAIL load_next: State=%0d ctrl=%b want 1 %b", State, ctrl, C_FETCH);
        end
        $display("[TB] LOAD transaction done");
    endtask

    // Starts in FETCH; table of STORE, ADD, SUB executions.
    task automatic test_mem_ops();
        logic [2:0] ops   [3] = '{3'b001, 3'b010, 3'b011};
        logic [3:0] exp_s [3] = '{4'd9, 4'd10, 4'd11};
        logic [9:0] exp_c [3] = '{C_STORE, C_ADD, C_SUB};
        for (int k = 0; k < 3; k++) begin
            int wr_cnt;
            int ld_cnt;
            wr_cnt = 0;
            ld_cnt = 0;
            IR = ops[k];
            for (int c = 0; c < 3; c++) begin
                #1;
                wr_cnt += int'(MemWr);
                ld_cnt += int'(Aload);
                step();
                if (c == 1) begin
                    tests++;
                    if (State !== exp_s[k] || ctrl !== exp_c[k]) begin
                        fails++;
                        $display("FAIL memop_exec[%0d]: State=%0d ctrl=%b want %0d %b", k, State, ctrl, exp_s[k], exp_c[k]);
                    end
                end
            end
            tests++;
            if (wr_cnt !== ((k == 0) ? 1 : 0) || ld_cnt !== ((k == 0) ? 0 : 1) || State !== 4'd1) begin
                fails++;
                $display("FAIL memop_pulses[%0d]: memwr=%0d aload=%0d State=%0d", k, wr_cnt, ld_cnt, State);
            end
            $display("[TB] opcode %b transaction done", ops[k]);
        end
    endtask

    // Starts in FETCH. Enter low 3 cycles in INPUT, high for 3 cycles, then low.
    task automatic test_input();
        logic [3:0] exp_s [8] = '{4'd12, 4'd12, 4'd12, 4'd12, 4'd3, 4'd3, 4'd3, 4'd1};
        logic       ent   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [9:0] exp_c [8] = '{C_IN0, C_IN0, C_IN0, C_IN1, C_NONE, C_NONE, C_NONE, C_FETCH};
        int aload_cnt;
        aload_cnt = 0;
        IR = 3'b100;
        Enter = 1'b0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            Enter = ent[i];
            #1;
            aload_cnt += int'(Aload);
            tests++;
            if (State !== exp_s[i] || ctrl !== exp_c[i]) begin
                fails++;
                $display("FAIL input_cyc[%0d]: State=%0d ctrl=%b want %0d %b", i, State, ctrl, exp_s[i], exp_c[i]);
            end
            if (i < 7) step();
        end
        tests++;
        if (aload_cnt !== 1) begin
            fails++;
            $display("FAIL input_aload_once: count=%0d want 1", aload_cnt);
        end
        $display("[TB] IN transaction done");
    endtask

    // Starts in FETCH. Jump conditions for JZ and JPOS.
    task automatic test_jumps();
        logic [2:0] ops   [4] = '{3'b101, 3'b101, 3'b110, 3'b110};
        logic       z     [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       p     [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_s [4] = '{4'd13, 4'd13, 4'd14, 4'd14};
        logic [9:0] exp_c [4] = '{C_JMP0, C_JMP1, C_JMP1, C_JMP0};
        for (int k = 0; k < 4; k++) begin
            IR = ops[k];
            Aeq0 = z[k];
            Apos = p[k];
            step();
            step();
            #1;
            tests++;
            if (State !== exp_s[k] || ctrl !== exp_c[k]) begin
                fails++;
                $display("FAIL jump[%0d]: State=%0d ctrl=%b want %0d %b", k, State, ctrl, exp_s[k], exp_c[k]);
            end
            step();
            $display("[TB] jump opcode %b Aeq0=%b Apos=%b done", ops[k], z[k], p[k]);
        end
        Aeq0 = 1'b0;
        Apos = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        IR = 3'b000;
        step();
        for (int n = 0; n < 255; n++) begin
            step();
            step();
            step();
        end
        tests++;
        if (InstrCount !== 8'd255 || State !== 4'd1) begin
            fails++;
            $display("FAIL wrap_255: cnt=%0d State=%0d want 255 1", InstrCount, State);
        end
        step();
        step();
        step();
        tests++;
        if (InstrCount !== 8'd0) begin
            fails++;
            $display("FAIL wrap_0: cnt=%0d want 0", InstrCount);
        end
        $display("[TB] 256 instructions decoded, count wrapped");
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        IR = 3'b111;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            Enter = i[0];
            #1;
            if (State !== 4'd15 || ctrl !== C_HALT) bad++;
            step();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL halt_hold: %0d bad cycles, last State=%0d ctrl=%b want 15 %b", bad, State, ctrl, C_HALT);
        end
        Enter = 1'b0;
        Reset = 1'b1;
        #1;
        tests++;
        if (State !== 4'd0 || Halt !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: State=%0d Halt=%b want 0 0", State, Halt);
        end
        step();
        Reset = 1'b0;
        $display("[TB] HALT transaction done");
    endtask

    initial begin
        test_reset();
        test_load();
        test_mem_ops();
        test_input();
        test_jumps();
        test_wrap();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
